// File: rtl/tl_multiway_ctrl.sv
// N-way actuated intersection controller: min/max green with gap-out, round-robin
// service of latched requests, all-red clearance and emergency preemption.
module tl_multiway_ctrl #(
    parameter int N_WAYS    = 4,
    parameter int MAIN_WAY  = 0,
    parameter int TMR_W     = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    localparam int WAY_W    = $clog2(N_WAYS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_WAYS-1:0]     car_sensor,
    input  logic                  emgcy_sensor,
    input  logic [WAY_W-1:0]      emgcy_way,
    output logic [3*N_WAYS-1:0]   lights,
    output logic [WAY_W-1:0]      green_way,
    output logic                  green_valid,
    output logic                  emgcy_active,
    output logic [N_WAYS-1:0]     req_pending
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_ALL_RED = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_OFF    = 3'd0;
    localparam logic [2:0] LAMP_RED    = 3'd1;
    localparam logic [2:0] LAMP_YELLOW = 3'd2;
    localparam logic [2:0] LAMP_GREEN  = 3'd3;

    localparam logic [TMR_W-1:0] GMIN_LAST = TMR_W'(GREEN_MIN - 1);
    localparam logic [TMR_W-1:0] GMAX_LAST = TMR_W'(GREEN_MAX - 1);
    localparam logic [TMR_W-1:0] YEL_LAST  = TMR_W'(YELLOW_T - 1);
    localparam logic [TMR_W-1:0] RED_LAST  = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] TMR_SAT   = {TMR_W{1'b1}};
    localparam logic [WAY_W-1:0] MAIN_IDX  = WAY_W'(MAIN_WAY);

    generate
        if (N_WAYS < 2 || N_WAYS > 8 || MAIN_WAY < 0 || MAIN_WAY >= N_WAYS ||
            TMR_W < 1 || TMR_W > 30 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
            GREEN_MAX > 2**TMR_W - 1 || YELLOW_T < 1 || YELLOW_T >= 2**TMR_W ||
            ALLRED_T < 1 || ALLRED_T >= 2**TMR_W) begin : g_bad_params
            $error("tl_multiway_ctrl: illegal parameter combination");
        end
    endgenerate

    state_t                state_reg, state_next;
    logic [TMR_W-1:0]      timer_reg, timer_next;
    logic [WAY_W-1:0]      way_reg, way_next;
    logic [N_WAYS-1:0]     req_reg, req_next;
    logic                  emgcy_reg;
    logic [3*N_WAYS-1:0]   lights_reg, lights_next;
    logic                  green_valid_reg;

    logic [N_WAYS-1:0]     way_onehot, grant_onehot;
    logic [WAY_W-1:0]      emgcy_tgt, rr_way;
    logic                  demand, green_exit, grant;

    always_comb begin
        way_onehot = '0;
        way_onehot[way_reg] = 1'b1;
    end

    assign emgcy_tgt = (int'(emgcy_way) >= N_WAYS) ? MAIN_IDX : emgcy_way;
    assign demand    = (|(req_reg & ~way_onehot)) || (way_reg != MAIN_IDX);

    // Scan farthest-first so the nearest requester after the current way wins.
    always_comb begin
        logic [WAY_W-1:0] cand;
        cand   = '0;
        rr_way = MAIN_IDX;
        for (int k = N_WAYS; k >= 1; k--) begin
            cand = WAY_W'((int'(way_reg) + k) % N_WAYS);
            if (req_reg[cand]) rr_way = cand;
        end
    end

    always_comb begin
        if (emgcy_reg)
            green_exit = (emgcy_tgt != way_reg);
        else
            green_exit = demand && (timer_reg >= GMIN_LAST) &&
                         (!car_sensor[way_reg] || (timer_reg >= GMAX_LAST));
    end

    always_comb begin
        state_next = state_reg;
        way_next   = way_reg;
        grant      = 1'b0;
        case (state_reg)
            ST_OFF:     state_next = ST_ALL_RED;
            ST_GREEN:   if (green_exit) state_next = ST_YELLOW;
            ST_YELLOW:  if (timer_reg == YEL_LAST) state_next = ST_ALL_RED;
            ST_ALL_RED: begin
                if (timer_reg == RED_LAST) begin
                    state_next = ST_GREEN;
                    grant      = 1'b1;
                    way_next   = emgcy_reg ? emgcy_tgt : rr_way;
                end
            end
        endcase

        if ((state_next != state_reg) || (state_reg == ST_OFF))
            timer_next = '0;
        else if (timer_reg == TMR_SAT)
            timer_next = timer_reg;
        else
            timer_next = timer_reg + 1'b1;

        grant_onehot = '0;
        if (grant) grant_onehot[way_next] = 1'b1;
    end

    // Per-way request latch and lamp decode; clearing on grant beats a new set.
    genvar gi;
    generate
        for (gi = 0; gi < N_WAYS; gi++) begin : g_way
            logic is_served;
            assign is_served = (way_next == WAY_W'(gi));
            assign req_next[gi] = (req_reg[gi] |
                                   (car_sensor[gi] & !((state_reg == ST_GREEN) && way_onehot[gi])))
                                  & !grant_onehot[gi];
            assign lights_next[3*gi +: 3] =
                (state_next == ST_OFF)                     ? LAMP_OFF   :
                ((state_next == ST_ALL_RED) || !is_served) ? LAMP_RED   :
                (state_next == ST_GREEN)                   ? LAMP_GREEN : LAMP_YELLOW;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_OFF;
            timer_reg       <= '0;
            way_reg         <= MAIN_IDX;
            req_reg         <= '0;
            emgcy_reg       <= 1'b0;
            lights_reg      <= '0;
            green_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            way_reg         <= way_next;
            req_reg         <= req_next;
            emgcy_reg       <= emgcy_sensor;
            lights_reg      <= lights_next;
            green_valid_reg <= (state_next == ST_GREEN);
        end
    end

    assign lights       = lights_reg;
    assign green_way    = way_reg;
    assign green_valid  = green_valid_reg;
    assign emgcy_active = emgcy_reg;
    assign req_pending  = req_reg;

endmodule

// File: tb/tb_tl_multiway_ctrl.sv
// Bench for tl_multiway_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a phase/dwell-time reference model.
module tb_tl_multiway_ctrl;

    localparam int NW = 4, MAINW = 0, GMIN = 4, GMAX = 10, YT = 2, AT = 1;
    localparam int PH_OFF = 0, PH_GREEN = 1, PH_YELLOW = 2, PH_ALLRED = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  car_sensor = '0;
    logic        emgcy_sensor = 1'b0;
    logic [1:0]  emgcy_way = '0;
    logic [11:0] lights;
    logic [1:0]  green_way;
    logic        green_valid, emgcy_active;
    logic [3:0]  req_pending;

    int vectors = 0;
    int miscompares = 0;

    tl_multiway_ctrl #(
        .N_WAYS(NW), .MAIN_WAY(MAINW), .TMR_W(4), .GREEN_MIN(GMIN),
        .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(AT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .car_sensor(car_sensor),
        .emgcy_sensor(emgcy_sensor), .emgcy_way(emgcy_way), .lights(lights),
        .green_way(green_way), .green_valid(green_valid),
        .emgcy_active(emgcy_active), .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    // Reference model: which phase, which way is served, how long we have dwelt.
    typedef struct {
        int     phase;
        int     way;
        int     age;
        bit [3:0] req;
        bit     em;
    } mstate_t;

    mstate_t m;

    function automatic int rr_pick(int from, bit [3:0] req);
        for (int step = 1; step <= NW; step++)
            if (req[(from + step) % NW]) return (from + step) % NW;
        return MAINW;
    endfunction

    function automatic mstate_t model_step(mstate_t s, bit [3:0] car, bit em, int ew);
        mstate_t n;
        int tgt;
        bit demand;
        bit leave;
        n = s;
        tgt = (ew >= NW) ? MAINW : ew;
        demand = (s.way != MAINW);
        for (int i = 0; i < NW; i++)
            if (i != s.way && s.req[i]) demand = 1'b1;
        for (int i = 0; i < NW; i++)
            if (car[i] && !(s.phase == PH_GREEN && i == s.way)) n.req[i] = 1'b1;
        n.em = em;
        n.age = s.age + 1;
        case (s.phase)
            PH_OFF: begin n.phase = PH_ALLRED; n.age = 0; end
            PH_GREEN: begin
                if (s.em) leave = (tgt != s.way);
                else leave = demand && s.age >= GMIN - 1 && (!car[s.way] || s.age >= GMAX - 1);
                if (leave) begin n.phase = PH_YELLOW; n.age = 0; end
            end
            PH_YELLOW: if (s.age == YT - 1) begin n.phase = PH_ALLRED; n.age = 0; end
            default: begin
                if (s.age == AT - 1) begin
                    n.phase = PH_GREEN;
                    n.age = 0;
                    n.way = s.em ? tgt : rr_pick(s.way, s.req);
                    n.req[n.way] = 1'b0;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [19:0] exp_obs(mstate_t s);
        logic [11:0] l;
        l = '0;
        for (int i = 0; i < NW; i++) begin
            if (s.phase == PH_ALLRED) l[3*i +: 3] = 3'd1;
            else if (s.phase == PH_GREEN) l[3*i +: 3] = (i == s.way) ? 3'd3 : 3'd1;
            else if (s.phase == PH_YELLOW) l[3*i +: 3] = (i == s.way) ? 3'd2 : 3'd1;
        end
        return {l, 2'(s.way), (s.phase == PH_GREEN), s.em, s.req};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '{PH_OFF, MAINW, 0, 4'b0, 1'b0};
        else m <= model_step(m, car_sensor, emgcy_sensor, int'(emgcy_way));
    end

    wire [19:0] dut_obs = {lights, green_way, green_valid, emgcy_active, req_pending};

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (lights !== 12'h000 || req_pending !== 4'h0 || green_valid !== 1'b0 ||
                emgcy_active !== 1'b0 || green_way !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_values: got %h want lights=000 others 0", dut_obs);
            end
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL reset_model: got %h want %h", dut_obs, exp_obs(m));
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (lights !== 12'h249 || dut_obs !== exp_obs(m)) begin
            miscompares++;
            $display("FAIL startup_allred: got %h want lights=249 obs=%h", dut_obs, exp_obs(m));
        end
        @(negedge clk);
        vectors++;
        if (lights !== 12'h24B || green_valid !== 1'b1 || dut_obs !== exp_obs(m)) begin
            miscompares++;
            $display("FAIL startup_main_green: got %h want lights=24b obs=%h", dut_obs, exp_obs(m));
        end
    endtask

    task automatic test_rest();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            vectors++;
            if (lights !== 12'h24B || green_way !== 2'd0 || green_valid !== 1'b1 ||
                dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL rest cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
        end
    endtask

    task automatic test_single_request();
        int onsets[$];
        int w2_len;
        bit prev_gv;
        w2_len = 0;
        car_sensor = 4'b0100;
        @(negedge clk);
        car_sensor = 4'b0000;
        vectors++;
        if (req_pending !== 4'b0100 || dut_obs !== exp_obs(m)) begin
            miscompares++;
            $display("FAIL single_req_latch: got %h want req=0100 obs=%h", dut_obs, exp_obs(m));
        end
        prev_gv = green_valid;
        for (int c = 0; c < 60 && onsets.size() < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL single_req cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            if (green_valid && !prev_gv) onsets.push_back(int'(green_way));
            if (green_valid && green_way == 2'd2) w2_len++;
            prev_gv = green_valid;
        end
        vectors++;
        if (onsets.size() != 2 || onsets[0] != 2 || onsets[1] != 0 || w2_len != 4) begin
            miscompares++;
            $display("FAIL single_req_sequence: got %0d onsets, way2 green %0d cycles want way2 then way0, 4 cycles",
                     onsets.size(), w2_len);
        end
    endtask

    task automatic test_gap_max();
        int stage, glen, want;
        bit done;
        for (int v = 0; v < 2; v++) begin
            stage = 0; glen = 0; done = 1'b0;
            want = (v == 0) ? GMAX : GMIN;
            car_sensor = 4'b0010;
            for (int c = 0; c < 300 && !done; c++) begin
                @(negedge clk);
                vectors++;
                if (dut_obs !== exp_obs(m)) begin
                    miscompares++;
                    $display("FAIL gap_max v%0d cyc %0d: got %h want %h", v, c, dut_obs, exp_obs(m));
                end
                case (stage)
                    0: if (m.phase == PH_GREEN && m.way == 1) begin car_sensor = 4'b0000; stage = 1; end
                    1: if (m.phase == PH_YELLOW && m.way == 1) begin car_sensor = 4'b0011; stage = 2; end
                    2: begin
                        car_sensor = (v == 0) ? 4'b0001 : 4'b0000;
                        if (lights[2:0] == 3'd3) begin glen++; stage = 3; end
                    end
                    default: if (lights[2:0] == 3'd3) glen++; else done = 1'b1;
                endcase
            end
            car_sensor = 4'b0000;
            vectors++;
            if (!done || glen != want) begin
                miscompares++;
                $display("FAIL gap_max_len v%0d: got %0d green cycles (done=%0d) want %0d", v, glen, done, want);
            end
        end
    endtask

    task automatic test_round_robin();
        int onsets[$];
        int nonred;
        bit prev_gv, ok;
        ok = 1'b0;
        for (int c = 0; c < 120 && !ok; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL rr_wait cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            ok = (m.phase == PH_GREEN && m.way == 0 && m.req == 4'b0);
        end
        car_sensor = 4'b1110;
        @(negedge clk);
        car_sensor = 4'b0000;
        prev_gv = green_valid;
        for (int c = 0; c < 120 && onsets.size() < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL rr cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            nonred = 0;
            for (int i = 0; i < NW; i++) if (lights[3*i +: 3] > 3'd1) nonred++;
            vectors++;
            if (nonred > 1) begin
                miscompares++;
                $display("FAIL rr_safety cyc %0d: got %0d non-red ways want <=1", c, nonred);
            end
            if (green_valid && !prev_gv) onsets.push_back(int'(green_way));
            prev_gv = green_valid;
        end
        vectors++;
        if (!ok || onsets.size() != 4 || onsets[0] != 1 || onsets[1] != 2 || onsets[2] != 3 || onsets[3] != 0) begin
            miscompares++;
            $display("FAIL rr_order: got %0d onsets %p want 1 2 3 0", onsets.size(), onsets);
        end
    endtask

    task automatic test_preempt();
        int hit_k, onset_way;
        bit ok, prev_gv;
        ok = 1'b0; hit_k = -1; onset_way = -1;
        for (int c = 0; c < 120 && !ok; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL preempt_wait cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            ok = (m.phase == PH_GREEN && m.way == 0 && m.req == 4'b0);
        end
        car_sensor = 4'b0010;
        @(negedge clk);
        car_sensor = 4'b0000;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL preempt_w1 cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            ok = (m.phase == PH_GREEN && m.way == 1 && m.age == 1);
        end
        emgcy_sensor = 1'b1;
        emgcy_way = 2'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL preempt k%0d: got %h want %h", k, dut_obs, exp_obs(m));
            end
            if (k == 1) begin
                vectors++;
                if (emgcy_active !== 1'b1) begin
                    miscompares++;
                    $display("FAIL preempt_active: got %b want 1", emgcy_active);
                end
            end
            if (k == 2) begin
                vectors++;
                if (lights[5:3] !== 3'd2) begin
                    miscompares++;
                    $display("FAIL preempt_yellow: got way1 lamp %0d want 2", lights[5:3]);
                end
            end
            if (hit_k < 0 && green_valid && green_way == 2'd3) hit_k = k;
        end
        vectors++;
        if (!ok || hit_k != 5) begin
            miscompares++;
            $display("FAIL preempt_latency: got way3 green at edge %0d want 5", hit_k);
        end
        for (int c = 0; c < 25; c++) begin
            car_sensor = (c == 5) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            vectors++;
            if (green_way !== 2'd3 || green_valid !== 1'b1 || dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL preempt_hold cyc %0d: got %h want way3 green obs=%h", c, dut_obs, exp_obs(m));
            end
        end
        car_sensor = 4'b0000;
        emgcy_sensor = 1'b0;
        prev_gv = green_valid;
        for (int c = 0; c < 40 && onset_way < 0; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL preempt_release cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            if (green_valid && !prev_gv) onset_way = int'(green_way);
            prev_gv = green_valid;
        end
        vectors++;
        if (onset_way != 1) begin
            miscompares++;
            $display("FAIL preempt_resume: got next green way %0d want 1", onset_way);
        end
    endtask

    task automatic test_random();
        bit em_on;
        int nonred;
        em_on = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            nonred = 0;
            for (int i = 0; i < NW; i++) if (lights[3*i +: 3] > 3'd1) nonred++;
            vectors++;
            if (nonred > 1) begin
                miscompares++;
                $display("FAIL random_safety cyc %0d: got %0d non-red ways want <=1", c, nonred);
            end
            car_sensor = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (em_on) begin
                if ($urandom_range(0, 15) == 0) em_on = 1'b0;
                else if ($urandom_range(0, 30) == 0) emgcy_way = 2'($urandom);
            end else if ($urandom_range(0, 79) == 0) begin
                em_on = 1'b1;
                emgcy_way = 2'($urandom);
            end
            emgcy_sensor = em_on;
        end
        car_sensor = 4'b0000;
        emgcy_sensor = 1'b0;
    endtask

    task automatic test_reset_mid_yellow();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 150 && !ok; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL rst_wait cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            ok = (m.phase == PH_GREEN && m.req == 4'b0 && !m.em);
        end
        car_sensor = 4'(1 << ((m.way + 2) % NW));
        @(negedge clk);
        car_sensor = 4'b0000;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_obs !== exp_obs(m)) begin
                miscompares++;
                $display("FAIL rst_yel_wait cyc %0d: got %h want %h", c, dut_obs, exp_obs(m));
            end
            ok = (m.phase == PH_YELLOW);
        end
        car_sensor = 4'b1000;
        @(negedge clk);
        car_sensor = 4'b0000;
        vectors++;
        if (!ok || lights === 12'h000 || dut_obs !== exp_obs(m)) begin
            miscompares++;
            $display("FAIL rst_pre_state: got %h want %h in yellow", dut_obs, exp_obs(m));
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (lights !== 12'h000 || req_pending !== 4'h0 || green_valid !== 1'b0 || emgcy_active !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got lights=%h req=%h gv=%b want all 0", lights, req_pending, green_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (lights !== 12'h249 || dut_obs !== exp_obs(m)) begin
            miscompares++;
            $display("FAIL rst_restart_allred: got %h want lights=249 obs=%h", dut_obs, exp_obs(m));
        end
        @(negedge clk);
        vectors++;
        if (lights !== 12'h24B || green_way !== 2'd0 || dut_obs !== exp_obs(m)) begin
            miscompares++;
            $display("FAIL rst_restart_green: got %h want lights=24b obs=%h", dut_obs, exp_obs(m));
        end
    endtask

    initial begin
        test_reset();
        test_rest();
        test_single_request();
        test_gap_max();
        test_round_robin();
        test_preempt();
        test_random();
        test_reset_mid_yellow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
